// File: rtl/node_link_if_pkg.sv
// Shared packet definitions and FSM state types for the node/router link.
package node_link_if_pkg;

  localparam int PKT_BYTES = 4;
  localparam int ID_W      = 4;

  typedef struct packed {
    logic [ID_W-1:0] src_id;
    logic [ID_W-1:0] dest_id;
    logic [23:0]     data;
  } pkt_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RECV,
    RX_HOLD
  } rx_state_e;

  function automatic logic [ID_W-1:0] dest_of(input pkt_t p);
    return p.dest_id;
  endfunction

endpackage

// File: rtl/link_tx_fifo.sv
// Small synchronous FIFO buffering outbound packets ahead of the serialiser.
module link_tx_fifo
  import node_link_if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_fire;
  logic             rd_fire;

  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_fire) - CW'(rd_fire);
    end
  end

  // Packet storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/node_link_if.sv
// Node-side link interface: FIFO-buffered byte serialiser toward the router
// and byte deserialiser with valid/ready hand-off from the router.
module node_link_if
  import node_link_if_pkg::*;
#(
  parameter int NODEID  = 0,
  parameter int TXDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] tx_pkt,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_pkt,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic        link_free_in,
  output logic        link_put_out,
  output logic [7:0]  link_payload_out,
  input  logic        link_put_in,
  input  logic [7:0]  link_payload_in,
  output logic        link_free_out,
  output logic        tx_self_err,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
);

  // ---------------- TX side ----------------
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        fifo_wr;
  logic [31:0] fifo_head;

  tx_state_e   tx_state, tx_state_nxt;
  logic [1:0]  tx_idx, tx_idx_nxt;
  logic [23:0] tx_shift, tx_shift_nxt;
  logic        put_nxt;
  logic [7:0]  payload_nxt;
  logic [15:0] tx_count_nxt;

  assign tx_ready = !fifo_full;
  assign fifo_wr  = tx_valid && !fifo_full;

  link_tx_fifo #(
    .DEPTH (TXDEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .wr_en   (fifo_wr),
    .wr_data (tx_pkt),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // TX next-state: launch byte0 on pop, stream bytes 1..3, then one put=0 gap cycle.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_idx_nxt   = tx_idx;
    tx_shift_nxt = tx_shift;
    put_nxt      = link_put_out;
    payload_nxt  = link_payload_out;
    tx_count_nxt = tx_count;
    fifo_rd      = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty && link_free_in) begin
          fifo_rd      = 1'b1;
          put_nxt      = 1'b1;
          payload_nxt  = fifo_head[31:24];
          tx_shift_nxt = fifo_head[23:0];
          tx_idx_nxt   = 2'd1;
          tx_state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        put_nxt      = 1'b1;
        payload_nxt  = tx_shift[23:16];
        tx_shift_nxt = {tx_shift[15:0], 8'h00};
        if (tx_idx == 2'(PKT_BYTES - 1)) begin
          tx_state_nxt = TX_GAP;
        end else begin
          tx_idx_nxt = tx_idx + 2'd1;
        end
      end
      TX_GAP: begin
        put_nxt      = 1'b0;
        payload_nxt  = 8'h00;
        tx_count_nxt = tx_count + 16'd1;
        tx_state_nxt = TX_IDLE;
      end
      default: begin
        put_nxt      = 1'b0;
        payload_nxt  = 8'h00;
        tx_state_nxt = TX_IDLE;
      end
    endcase
  end

  // TX control and registered link outputs; reset drops put immediately.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx_state         <= TX_IDLE;
      tx_idx           <= '0;
      link_put_out     <= 1'b0;
      link_payload_out <= 8'h00;
      tx_count         <= 16'h0000;
      tx_self_err      <= 1'b0;
    end else begin
      tx_state         <= tx_state_nxt;
      tx_idx           <= tx_idx_nxt;
      link_put_out     <= put_nxt;
      link_payload_out <= payload_nxt;
      tx_count         <= tx_count_nxt;
      if (fifo_wr && (dest_of(tx_pkt) == ID_W'(NODEID))) tx_self_err <= 1'b1;
    end
  end

  // Remaining bytes of the packet being serialised.
  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_nxt;
  end

  // ---------------- RX side ----------------
  rx_state_e   rx_state, rx_state_nxt;
  logic [1:0]  rx_idx, rx_idx_nxt;
  logic [23:0] rx_buf, rx_buf_nxt;
  logic        free_nxt;
  logic        rx_valid_nxt;
  logic [31:0] rx_pkt_nxt;
  logic [15:0] rx_count_nxt;

  // RX next-state: collect 4 consecutive put bytes, abort on a put gap, hold until accepted.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_idx_nxt   = rx_idx;
    rx_buf_nxt   = rx_buf;
    free_nxt     = link_free_out;
    rx_valid_nxt = rx_valid;
    rx_pkt_nxt   = rx_pkt;
    rx_count_nxt = rx_count;
    unique case (rx_state)
      RX_IDLE: begin
        if (link_put_in) begin
          rx_buf_nxt   = {16'h0000, link_payload_in};
          rx_idx_nxt   = 2'd1;
          free_nxt     = 1'b0;
          rx_state_nxt = RX_RECV;
        end else begin
          free_nxt = !rx_valid;
        end
      end
      RX_RECV: begin
        if (!link_put_in) begin
          free_nxt     = 1'b1;
          rx_state_nxt = RX_IDLE;
        end else if (rx_idx == 2'(PKT_BYTES - 1)) begin
          rx_pkt_nxt   = {rx_buf, link_payload_in};
          rx_valid_nxt = 1'b1;
          rx_state_nxt = RX_HOLD;
        end else begin
          rx_buf_nxt = {rx_buf[15:0], link_payload_in};
          rx_idx_nxt = rx_idx + 2'd1;
        end
      end
      RX_HOLD: begin
        free_nxt = 1'b0;
        if (rx_ready) begin
          rx_valid_nxt = 1'b0;
          rx_count_nxt = rx_count + 16'd1;
          free_nxt     = 1'b1;
          rx_state_nxt = RX_IDLE;
        end
      end
      default: begin
        free_nxt     = 1'b0;
        rx_valid_nxt = 1'b0;
        rx_state_nxt = RX_IDLE;
      end
    endcase
  end

  // RX control and registered node-facing outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rx_state      <= RX_IDLE;
      rx_idx        <= '0;
      link_free_out <= 1'b0;
      rx_valid      <= 1'b0;
      rx_pkt        <= 32'h0;
      rx_count      <= 16'h0000;
    end else begin
      rx_state      <= rx_state_nxt;
      rx_idx        <= rx_idx_nxt;
      link_free_out <= free_nxt;
      rx_valid      <= rx_valid_nxt;
      rx_pkt        <= rx_pkt_nxt;
      rx_count      <= rx_count_nxt;
    end
  end

  // Partially assembled inbound bytes.
  always_ff @(posedge clk) begin
    rx_buf <= rx_buf_nxt;
  end

endmodule
